// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command sequencer and its target: op encoding,
// command bytes, FSM states and the latched request payload.
package spi_pkg;

   localparam int unsigned N_REQ  = 2;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [OP_W-1:0] {
      OP_READ   = 2'b00,
      OP_WRITE  = 2'b01,
      OP_STREAM = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   localparam logic [BYTE_W-1:0] CMD_READ   = 8'h03;
   localparam logic [BYTE_W-1:0] CMD_WRITE  = 8'h02;
   localparam logic [BYTE_W-1:0] CMD_STREAM = 8'h80;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      ADDR    = 3'd2,
      DATA    = 3'd3,
      CAPTURE = 3'd4
   } state_e;

   typedef struct packed {
      op_e               op;
      logic [ADDR_W-1:0] addr;
      logic [BYTE_W-1:0] data;
   } cmd_t;

   function automatic logic [BYTE_W-1:0] cmd_byte(input op_e op);
      case (op)
         OP_READ:   cmd_byte = CMD_READ;
         OP_WRITE:  cmd_byte = CMD_WRITE;
         default:   cmd_byte = CMD_STREAM;
      endcase
   endfunction

endpackage

// File: rtl/spi_seq_arbiter.sv
// Two-requester arbiter: priority starts at the requester named by ptr.
module spi_seq_arbiter
   import spi_pkg::*;
(
   input  logic [N_REQ-1:0] req_valid,
   input  logic             ptr,
   input  logic             enable,
   output logic [N_REQ-1:0] grant_c
);

   always_comb begin
      grant_c = '0;
      if (enable) begin
         if (req_valid[ptr])       grant_c[ptr]  = 1'b1;
         else if (req_valid[~ptr]) grant_c[~ptr] = 1'b1;
      end
   end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Arbitrates two requesters and sequences READ/WRITE/STREAM commands onto a byte-wide SPI bus.
// Define SPI_SEQ_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module spi_cmd_sequencer
   import spi_pkg::*;
#(
   parameter logic [7:0] IDLE_BYTE = 8'h00
) (
   input  logic        sclk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req_op,
   input  logic [9:0]  req_addr,
   input  logic [15:0] req_data,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [7:0]  rsp_data,
   output logic        rsp_err,
   output logic        cs,
   output logic [7:0]  mosi,
   input  logic [7:0]  miso,
   output logic        busy
);

   state_e      state_q, state_d;
   cmd_t        cmd_q, cmd_d;
   logic        id_q, id_d;
   logic        cap_wait_q, cap_wait_d;
   logic        ptr_q, ptr_d;
   logic [7:0]  mosi_d, rsp_data_d;
   logic        cs_d, rsp_valid_d, rsp_id_d, rsp_err_d;
   logic [1:0]  accept_c, grant_c;
   logic        acc_id_c;
   cmd_t        req_cmd_c;

   assign accept_c  = req_valid & req_ready;
   assign acc_id_c  = accept_c[1];
   assign req_cmd_c = acc_id_c
                    ? cmd_t'{op: op_e'(req_op[3:2]), addr: req_addr[9:5], data: req_data[15:8]}
                    : cmd_t'{op: op_e'(req_op[1:0]), addr: req_addr[4:0], data: req_data[7:0]};

   spi_seq_arbiter u_arb (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .enable    (state_d == IDLE),
      .grant_c   (grant_c)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      id_d        = id_q;
      cap_wait_d  = 1'b0;
      ptr_d       = ptr_q;
      mosi_d      = mosi;
      cs_d        = cs;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id;
      rsp_data_d  = '0;
      rsp_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (|accept_c) begin
               cmd_d   = req_cmd_c;
               id_d    = acc_id_c;
               state_d = CMD;
`ifdef SPI_SEQ_ROUND_ROBIN_EN
               ptr_d   = ~acc_id_c;
`endif
               // Reserved ops occupy CMD for one cycle with the bus left idle
               if (req_cmd_c.op != OP_RSVD) begin
                  mosi_d = cmd_byte(req_cmd_c.op);
                  cs_d   = 1'b1;
               end
            end
         end
         CMD: begin
            case (cmd_q.op)
               OP_READ, OP_WRITE: begin
                  state_d = ADDR;
                  mosi_d  = {3'b000, cmd_q.addr};
               end
               OP_STREAM: begin
                  state_d = DATA;
                  mosi_d  = cmd_q.data;
               end
               default: begin
                  state_d     = IDLE;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_id_d    = id_q;
               end
            endcase
         end
         ADDR: begin
            if (cmd_q.op == OP_WRITE) begin
               state_d = DATA;
               mosi_d  = cmd_q.data;
            end else begin
               state_d    = CAPTURE;
               mosi_d     = IDLE_BYTE;
               cs_d       = 1'b0;
               cap_wait_d = 1'b1;
            end
         end
         CAPTURE: begin
            // First cycle is the target's turnaround; miso is sampled on the second edge
            if (!cap_wait_q) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_data_d  = miso;
               rsp_id_d    = id_q;
            end
         end
         DATA: begin
            state_d     = IDLE;
            mosi_d      = IDLE_BYTE;
            cs_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
         end
         default: begin
            state_d = IDLE;
            mosi_d  = IDLE_BYTE;
            cs_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         id_q       <= 1'b0;
         cap_wait_q <= 1'b0;
         ptr_q      <= 1'b0;
         mosi       <= IDLE_BYTE;
         cs         <= 1'b0;
         req_ready  <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         id_q       <= id_d;
         cap_wait_q <= cap_wait_d;
         ptr_q      <= ptr_d;
         mosi       <= mosi_d;
         cs         <= cs_d;
         req_ready  <= grant_c;
         rsp_valid  <= rsp_valid_d;
         rsp_id     <= rsp_id_d;
         rsp_data   <= rsp_data_d;
         rsp_err    <= rsp_err_d;
         busy       <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: randomized requests, a transaction-level
// reference model, a behavioural SPI target and an independent response monitor.
module tb_spi_cmd_sequencer;

   localparam logic [7:0] IDLE_B = 8'h00;

   logic        sclk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_op;
   logic [9:0]  req_addr;
   logic [15:0] req_data;
   logic        rsp_valid;
   logic        rsp_id;
   logic [7:0]  rsp_data;
   logic        rsp_err;
   logic        cs;
   logic [7:0]  mosi;
   logic [7:0]  miso;
   logic        busy;

   spi_cmd_sequencer #(.IDLE_BYTE(IDLE_B)) dut (
      .sclk      (sclk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .cs        (cs),
      .mosi      (mosi),
      .miso      (miso),
      .busy      (busy)
   );

   always #5 sclk = ~sclk;

   typedef struct {
      int op;
      int addr;
      int data;
   } txn_t;

   typedef struct {
      int id;
      int err;
      int data;
      int lat;
      int acc;
      int nb;
   } exp_t;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          rr_ptr = 0;
   txn_t        pend0[$];
   txn_t        pend1[$];
   exp_t        sb[$];
   logic [7:0]  exp_b[$];
   logic [7:0]  got_b[$];
   logic [7:0]  rmem[16];
   logic [7:0]  tmem[16];
   exp_t        me;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(posedge sclk) cyc <= cyc + 1;

   // Behavioural SPI target: decodes the byte stream framed by cs
   int         t_pos = 0;
   logic [7:0] t_cmd, t_addr;
   always @(negedge sclk) begin
      if (cs) begin
         if (t_pos == 0) begin
            t_cmd = mosi;
            miso  = 8'($urandom_range(0, 255));
         end else if (t_pos == 1) begin
            t_addr = mosi;
            if (t_cmd == 8'h03) miso = tmem[t_addr[3:0]];
         end else if (t_pos == 2 && t_cmd == 8'h02) begin
            tmem[t_addr[3:0]] = mosi;
         end
         t_pos++;
      end else begin
         t_pos = 0;
      end
   end

   // Response monitor: collects framed bytes and retires scoreboard entries
   always @(negedge sclk) begin
      if (!rst_n) begin
         got_b.delete();
      end else begin
         if (cs) got_b.push_back(mosi);
         else    check("mosi_idle", 32'(mosi), 32'(IDLE_B));
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", 32'(rsp_valid), 32'(0));
            end else begin
               me = sb.pop_front();
               check("rsp_id",      32'(rsp_id),       32'(me.id));
               check("rsp_err",     32'(rsp_err),      32'(me.err));
               check("rsp_data",    32'(rsp_data),     32'(me.data));
               check("rsp_latency", 32'(cyc),          32'(me.acc + me.lat));
               check("byte_count",  32'(got_b.size()), 32'(me.nb));
               for (int j = 0; j < me.nb; j++) begin
                  logic [7:0] b;
                  b = exp_b.pop_front();
                  if (j < got_b.size()) check("mosi_byte", 32'(got_b[j]), 32'(b));
               end
               got_b.delete();
            end
         end
      end
   end

   function automatic logic [1:0] want_grant();
`ifdef SPI_SEQ_ROUND_ROBIN_EN
      want_grant = (rr_ptr == 0) ? 2'b01 : 2'b10;
`else
      want_grant = 2'b01;
`endif
   endfunction

   // Transaction-level reference: bytes on the wire, result and latency per op
   task automatic expect_txn(input int id, input txn_t t);
      exp_t e;
      e.id = id; e.acc = cyc + 1; e.err = 0; e.data = 0;
      case (t.op)
         0: begin
            e.lat = 4; e.nb = 2; e.data = int'(rmem[t.addr % 16]);
            exp_b.push_back(8'h03); exp_b.push_back(8'(t.addr));
         end
         1: begin
            e.lat = 3; e.nb = 3; rmem[t.addr % 16] = 8'(t.data);
            exp_b.push_back(8'h02); exp_b.push_back(8'(t.addr)); exp_b.push_back(8'(t.data));
         end
         2: begin
            e.lat = 2; e.nb = 2;
            exp_b.push_back(8'h80); exp_b.push_back(8'(t.data));
         end
         default: begin
            e.lat = 1; e.nb = 0; e.err = 1;
         end
      endcase
      sb.push_back(e);
   endtask

   task automatic drive(input int i, input txn_t t);
      if (i == 0) begin
         req_op[1:0] = 2'(t.op); req_addr[4:0] = 5'(t.addr); req_data[7:0] = 8'(t.data);
      end else begin
         req_op[3:2] = 2'(t.op); req_addr[9:5] = 5'(t.addr); req_data[15:8] = 8'(t.data);
      end
      req_valid[i] = 1'b1;
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      int   r;
      r = int'($urandom_range(0, 9));
      t.op   = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      t.addr = int'($urandom_range(0, 31));
      t.data = int'($urandom_range(0, 255));
      return t;
   endfunction

   task automatic run_phase(input bit allow_drop, input int budget);
      logic [1:0] pv, acc;
      int         iter;
      txn_t       t;
      pv   = req_valid;
      iter = 0;
      while ((pend0.size() + pend1.size()) != 0 || req_valid != 2'b00) begin
         @(negedge sclk);
         if (req_ready != 2'b00) begin
            check("ready_onehot", 32'($onehot(req_ready)), 32'(1));
            check("ready_needs_valid", 32'(|(req_ready & pv)), 32'(1));
            if (pv == 2'b11) check("arb_policy", 32'(req_ready), 32'(want_grant()));
         end
         if (busy) check("ready_when_busy", 32'(req_ready), 32'(0));
         acc = req_valid & req_ready;
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               t = (i == 0) ? pend0[0] : pend1[0];
               expect_txn(i, t);
               rr_ptr = 1 - i;
            end
         end
         pv = req_valid;
         @(posedge sclk);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               if (i == 0) void'(pend0.pop_front()); else void'(pend1.pop_front());
               req_valid[i] = 1'b0;
            end
            if (!req_valid[i]) begin
               if ((i == 0 ? pend0.size() : pend1.size()) != 0 &&
                   (!allow_drop || $urandom_range(0, 2) != 0))
                  drive(i, (i == 0) ? pend0[0] : pend1[0]);
            end else if (allow_drop && $urandom_range(0, 7) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         iter++;
         if (iter > budget) begin
            check("phase_timeout", 32'(iter), 32'(budget));
            req_valid = 2'b00;
            pend0.delete();
            pend1.delete();
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge sclk);
         n++;
      end
      check("drain_empty", 32'(sb.size()), 32'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mosi"},      32'(mosi),      32'(IDLE_B));
      check({tag, "_cs"},        32'(cs),        32'(0));
      check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
      check({tag, "_rsp_id"},    32'(rsp_id),    32'(0));
      check({tag, "_rsp_data"},  32'(rsp_data),  32'(0));
      check({tag, "_rsp_err"},   32'(rsp_err),   32'(0));
      check({tag, "_busy"},      32'(busy),      32'(0));
   endtask

   initial begin
      txn_t t;
      int   n;
      rst_n = 1'b0; req_valid = 2'b00; req_op = '0; req_addr = '0; req_data = '0; miso = '0;
      for (int i = 0; i < 16; i++) begin
         rmem[i] = 8'($urandom_range(0, 255));
         tmem[i] = rmem[i];
      end
      repeat (2) @(negedge sclk);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Directed: WRITE A5 @3, READ @3 from req1, STREAM 'A', reserved op
      t = '{op: 1, addr: 3, data: 8'hA5}; pend0.push_back(t);
      t = '{op: 2, addr: 0, data: 8'h41}; pend0.push_back(t);
      t = '{op: 3, addr: 0, data: 0};     pend0.push_back(t);
      t = '{op: 0, addr: 3, data: 0};     pend1.push_back(t);
      run_phase(1'b0, 200);
      drain();

      // Both requesters continuously valid, four WRITEs each
      for (int k = 0; k < 4; k++) begin
         t = '{op: 1, addr: k, data: 8'h10 + k}; pend0.push_back(t);
         t = '{op: 1, addr: k + 8, data: 8'h20 + k}; pend1.push_back(t);
      end
      run_phase(1'b0, 200);
      drain();

      // Random traffic with valid drops
      for (int k = 0; k < 40; k++) begin
         pend0.push_back(rand_txn());
         pend1.push_back(rand_txn());
      end
      run_phase(1'b1, 4000);
      drain();

      // Reset during the ADDR phase of a READ: abort with no response
      @(negedge sclk);
      t = '{op: 0, addr: 5, data: 0};
      drive(0, t);
      n = 0;
      @(negedge sclk);
      while (!(req_ready[0]) && n < 10) begin
         @(negedge sclk);
         n++;
      end
      check("rst_test_ready", 32'(req_ready[0]), 32'(1));
      @(posedge sclk);
      #1 req_valid = 2'b00;
      @(negedge sclk);
      @(negedge sclk);
      check("rst_test_addr_cs",   32'(cs),   32'(1));
      check("rst_test_addr_mosi", 32'(mosi), 32'(5));
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      @(posedge sclk);
      #1 check_reset_outputs("held_reset");
      @(negedge sclk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge sclk);
         check("post_reset_no_rsp", 32'(rsp_valid), 32'(0));
         check("post_reset_idle",   32'(busy),      32'(0));
      end
      check("sb_final_empty", 32'(sb.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
